// File: rtl/rtc_bus_cycle.sv
// ============================================================================
// Module   : rtc_bus_cycle
// Purpose  : Multiplexed address/data RTC bus cycle generator (CS/RD/WR/AD).
//            Optional one-entry request buffer enabled by RTC_BUS_QUEUE_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rtc_bus_cycle #(
  parameter int unsigned PHASE_CYC = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       rw,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       done,
  output logic       CS,
  output logic       RD,
  output logic       WR,
  output logic       AD,
  inout  wire  [7:0] DatAdd
);

  localparam logic [7:0] c_phase_last = 8'(PHASE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_A_SET   = 3'd1,
    S_A_LATCH = 3'd2,
    S_D_ACT   = 3'd3,
    S_D_HOLD  = 3'd4,
    S_RECOV   = 3'd5
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_cnt;
  logic       r_rw;
  logic [7:0] r_addr;
  logic [7:0] r_wdata;
  logic [7:0] r_rdata;
  logic       r_done;

  logic       w_phase_end;
  logic       w_recov_end;
  logic       w_launch;
  logic       w_launch_rw;
  logic [7:0] w_launch_addr;
  logic [7:0] w_launch_wdata;
  logic       w_drive;
  logic [7:0] w_bus_out;

  assign w_phase_end = (r_cnt == 8'd0);
  assign w_recov_end = (r_state == S_RECOV) && w_phase_end;

`ifdef RTC_BUS_QUEUE_EN
  logic       r_q_full;
  logic       r_q_rw;
  logic [7:0] r_q_addr;
  logic [7:0] r_q_wdata;
  logic       w_q_push;
  logic       w_q_pop;

  // A start landing on the RECOV-end edge with an empty buffer launches directly
  assign w_q_pop  = w_recov_end && r_q_full;
  assign w_q_push = start && (r_state != S_IDLE) && !r_q_full && !w_recov_end;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q_full  <= 1'b0;
      r_q_rw    <= 1'b0;
      r_q_addr  <= 8'h00;
      r_q_wdata <= 8'h00;
    end else if (w_q_pop) begin
      r_q_full <= 1'b0;
    end else if (w_q_push) begin
      r_q_full  <= 1'b1;
      r_q_rw    <= rw;
      r_q_addr  <= addr;
      r_q_wdata <= wdata;
    end
  end
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_launch       = 1'b0;
    w_launch_rw    = rw;
    w_launch_addr  = addr;
    w_launch_wdata = wdata;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_A_SET;
          w_launch    = 1'b1;
        end
      end
      S_A_SET:   if (w_phase_end) w_state_nxt = S_A_LATCH;
      S_A_LATCH: if (w_phase_end) w_state_nxt = S_D_ACT;
      S_D_ACT:   if (w_phase_end) w_state_nxt = S_D_HOLD;
      S_D_HOLD:  if (w_phase_end) w_state_nxt = S_RECOV;
      S_RECOV: begin
        if (w_phase_end) begin
`ifdef RTC_BUS_QUEUE_EN
          if (r_q_full) begin
            w_state_nxt    = S_A_SET;
            w_launch       = 1'b1;
            w_launch_rw    = r_q_rw;
            w_launch_addr  = r_q_addr;
            w_launch_wdata = r_q_wdata;
          end else if (start) begin
            w_state_nxt = S_A_SET;
            w_launch    = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 8'd0;
      r_rw    <= 1'b0;
      r_addr  <= 8'h00;
      r_wdata <= 8'h00;
      r_rdata <= 8'h00;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_recov_end;
      // Reload on every state entry, including RECOV -> A_SET relaunch
      if (w_state_nxt != r_state) begin
        r_cnt <= c_phase_last;
      end else if (r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
      if (w_launch) begin
        r_rw    <= w_launch_rw;
        r_addr  <= w_launch_addr;
        r_wdata <= w_launch_wdata;
      end
      if ((r_state == S_D_ACT) && r_rw && w_phase_end) begin
        r_rdata <= DatAdd;
      end
    end
  end

  always_comb begin
    CS        = 1'b1;
    RD        = 1'b1;
    WR        = 1'b1;
    AD        = 1'b1;
    w_drive   = 1'b0;
    w_bus_out = r_wdata;
    case (r_state)
      S_A_SET: begin
        CS        = 1'b0;
        AD        = 1'b0;
        WR        = 1'b0;
        w_drive   = 1'b1;
        w_bus_out = r_addr;
      end
      S_A_LATCH: begin
        CS        = 1'b0;
        AD        = 1'b0;
        w_drive   = 1'b1;
        w_bus_out = r_addr;
      end
      S_D_ACT: begin
        CS      = 1'b0;
        RD      = !r_rw;
        WR      = r_rw;
        w_drive = !r_rw;
      end
      S_D_HOLD: begin
        CS      = 1'b0;
        w_drive = !r_rw;
      end
      default: ;
    endcase
  end

  assign DatAdd = w_drive ? w_bus_out : 8'hzz;
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign rdata  = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_rtc_bus_cycle.sv
// ============================================================================
// Module   : tb_rtc_bus_cycle
// Purpose  : Self-checking bench for rtc_bus_cycle with a behavioural RTC model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rtc_bus_cycle;

  localparam int P = 4;
  localparam int XFER = 5 * P;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       busy, done, CS, RD, WR, AD;
  wire  [7:0] DatAdd;

  logic [7:0] rtc_val = 8'h00;
  logic [7:0] exp_rdata = 8'h00;
  int n_cmp = 0;
  int n_fail = 0;

  rtc_bus_cycle #(.PHASE_CYC(P)) dut (
    .clk(clk), .reset(reset), .start(start), .rw(rw), .addr(addr),
    .wdata(wdata), .rdata(rdata), .busy(busy), .done(done),
    .CS(CS), .RD(RD), .WR(WR), .AD(AD), .DatAdd(DatAdd)
  );

  always #5 clk = ~clk;

  // RTC answers reads while RD is low; an undriven bus floats to 8'hFF
  assign DatAdd = (RD == 1'b0) ? rtc_val : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (DatAdd[i]);
  end

  // Expected {busy,done,CS,RD,WR,AD,DatAdd} for cycle k after the start edge
  function automatic logic [13:0] model_out(int k, logic t_rw, logic [7:0] a,
                                            logic [7:0] w, logic [7:0] r);
    int ph = (k - 1) / P;
    logic b  = (k >= 1) && (k <= XFER);
    logic d  = (k == XFER + 1);
    logic cs = !(b && ph <= 3);
    logic ad = !(b && ph <= 1);
    logic wr = !(b && (ph == 0 || (ph == 2 && !t_rw)));
    logic rd = !(b && ph == 2 && t_rw);
    logic [7:0] bus = 8'hff;
    if (b && ph <= 1) bus = a;
    else if (b && !t_rw && (ph == 2 || ph == 3)) bus = w;
    else if (b && t_rw && ph == 2) bus = r;
    return {b, d, cs, rd, wr, ad, bus};
  endfunction

  task automatic test_reset();
    logic [13:0] got;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    got = {busy, done, CS, RD, WR, AD, DatAdd};
    n_cmp++;
    if (got !== 14'b00_1111_11111111) begin
      n_fail++;
      $display("FAIL reset_idle: got %h required %h", got, 14'b00_1111_11111111);
    end
    n_cmp++;
    if (rdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h required 00", rdata);
    end
    // start must be taken on the very first edge after release
    reset = 1'b1; start = 1'b1; rw = 1'b0; addr = 8'h33; wdata = 8'h12;
    @(posedge clk); #1; start = 1'b0;
    n_cmp++;
    if ({busy, AD} !== 2'b10) begin
      n_fail++;
      $display("FAIL reset_first_start: busy/AD got %b required 10", {busy, AD});
    end
    repeat (XFER) begin @(posedge clk); #1; end
    n_cmp++;
    if ({busy, done} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_first_done: busy/done got %b required 01", {busy, done});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_transfers();
    logic t_rw;
    logic [7:0] t_a, t_w, t_r;
    logic [13:0] got, exp;
    for (int n = 0; n < 8; n++) begin
      if (n == 0) begin
        t_rw = 1'b0; t_a = 8'h21; t_w = 8'h45; t_r = 8'h00;
      end else if (n == 1) begin
        t_rw = 1'b1; t_a = 8'h00; t_w = 8'h9c; t_r = 8'h59;
      end else begin
        t_rw = 1'($urandom_range(0, 1));
        t_a  = 8'($urandom_range(0, 254));
        t_w  = 8'($urandom_range(0, 254));
        t_r  = 8'($urandom_range(0, 254));
      end
      @(negedge clk);
      rw = t_rw; addr = t_a; wdata = t_w; rtc_val = t_r; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int k = 1; k <= XFER + 1; k++) begin
        if (t_rw && k == 3 * P + 1) exp_rdata = t_r;
        exp = model_out(k, t_rw, t_a, t_w, t_r);
        got = {busy, done, CS, RD, WR, AD, DatAdd};
        n_cmp++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL xfer%0d_cycle%0d: {busy,done,CS,RD,WR,AD,DatAdd} got %h required %h",
                   n, k, got, exp);
        end
        n_cmp++;
        if (rdata !== exp_rdata) begin
          n_fail++;
          $display("FAIL xfer%0d_cycle%0d_rdata: got %h required %h", n, k, rdata, exp_rdata);
        end
        @(posedge clk); #1;
      end
    end
  endtask

`ifdef RTC_BUS_QUEUE_EN
  task automatic test_queue();
    logic [13:0] got, exp;
    int ndone = 0;
    @(negedge clk);
    rw = 1'b0; addr = 8'h21; wdata = 8'h45; rtc_val = 8'h66; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 2 * XFER + 1; k++) begin
      start = 1'b0;
      if (k == 10) begin rw = 1'b1; addr = 8'h3c; wdata = 8'h00; start = 1'b1; end
      if (k <= XFER) exp = model_out(k, 1'b0, 8'h21, 8'h45, 8'h00);
      else exp = model_out(k - XFER, 1'b1, 8'h3c, 8'h00, 8'h66);
      if (k == XFER + 1) exp[12] = 1'b1;
      if (k == XFER + 3 * P + 1) exp_rdata = 8'h66;
      if (done) ndone++;
      got = {busy, done, CS, RD, WR, AD, DatAdd};
      n_cmp++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL queue_cycle%0d: {busy,done,CS,RD,WR,AD,DatAdd} got %h required %h",
                 k, got, exp);
      end
      n_cmp++;
      if (rdata !== exp_rdata) begin
        n_fail++;
        $display("FAIL queue_cycle%0d_rdata: got %h required %h", k, rdata, exp_rdata);
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 2) begin
      n_fail++;
      $display("FAIL queue_done_count: got %0d required 2", ndone);
    end
  endtask
`else
  task automatic test_back_to_back();
    int ndone = 0;
    @(negedge clk);
    rw = 1'b0; addr = 8'h5a; wdata = 8'ha5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      start = (k == 5);
      if (k == 5) begin rw = 1'b1; addr = 8'h77; end
      if (done) ndone++;
      n_cmp++;
      if ({busy, done} !== {1'(k <= XFER), 1'(k == XFER + 1)}) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: busy/done got %b required %b", k, {busy, done},
                 {1'(k <= XFER), 1'(k == XFER + 1)});
      end
      if (k <= 2 * P) begin
        n_cmp++;
        if (DatAdd !== 8'h5a) begin
          n_fail++;
          $display("FAIL b2b_cycle%0d_addr: got %h required 5a", k, DatAdd);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_cmp++;
    if (ndone != 1) begin
      n_fail++;
      $display("FAIL b2b_done_count: got %0d required 1", ndone);
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [13:0] got;
    @(negedge clk);
    rw = 1'b0; addr = 8'h21; wdata = 8'h45; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 reset = 1'b0;
    #1;
    got = {busy, done, CS, RD, WR, AD, DatAdd};
    n_cmp++;
    if (got !== 14'b00_1111_11111111) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %h required %h", got, 14'b00_1111_11111111);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      got = {busy, done, CS, RD, WR, AD, DatAdd};
      n_cmp++;
      if (got !== 14'b00_1111_11111111 || rdata !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mid_after%0d: got %h rdata %h required %h rdata 00",
                 k, got, rdata, 14'b00_1111_11111111);
      end
    end
  endtask

  initial begin
    test_reset();
    test_transfers();
`ifdef RTC_BUS_QUEUE_EN
    test_queue();
`else
    test_back_to_back();
`endif
    exp_rdata = 8'h00;
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
